// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Default vector addresses (reset, interrupt, exception entry points)
//   - NOP_INSTR: the instruction word presented in an IF/ID bubble
//   - redir_e: per-cycle PC/IF-IF/ID update selection, highest priority first
//   - pc_increment(): sequential PC step that keeps the supervisor bit
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [2:0] {
        REDIR_NONE = 3'd0,  // sequential fetch
        REDIR_BR   = 3'd1,  // taken branch from EX
        REDIR_EXC  = 3'd2,  // undefined instruction in ID
        REDIR_IRQ  = 3'd3,  // interrupt accepted
        REDIR_HOLD = 3'd4,  // load-use stall
        REDIR_JMP  = 3'd5   // jump resolved in ID
    } redir_e;

    // Bit 31 selects supervisor space and is never carried into; the
    // remaining 31 bits wrap on their own.
    function automatic logic [31:0] pc_increment(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the IF/ID register
// outputs consumed by decode and the hazard/branch logic.
//   master (if_stage): drives imem_addr and ifid_*, reads imem_rdata
//   slave  (memory/decode side): the mirror image
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        ifid_irq;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid,
        output ifid_irq
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid,
        input  ifid_irq
    );
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   hold           keep every field unchanged (takes precedence over load)
//   bubble         load a NOP with valid=0 instead of the fetched word
//   irq_tag        with bubble: mark it as an interrupt bubble and load pc4_in
//                  (the return address); otherwise pc4 is left untouched
//   instr_in       fetched instruction
//   pc4_in         PC+4 of instr_in, or the return address for irq bubbles
//   instr/pc4/valid/irq   registered outputs
import if_stage_pkg::*;

module if_stage_ifid_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  logic        irq_tag,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid,
    output logic        irq
);

    logic [31:0] instr_reg;
    logic [31:0] pc4_reg;
    logic        valid_reg;
    logic        irq_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg <= NOP_INSTR;
            pc4_reg   <= 32'h0;
            valid_reg <= 1'b0;
            irq_reg   <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                instr_reg <= NOP_INSTR;
                valid_reg <= 1'b0;
                irq_reg   <= irq_tag;
                if (irq_tag) begin
                    pc4_reg <= pc4_in;
                end
            end else begin
                instr_reg <= instr_in;
                pc4_reg   <= pc4_in;
                valid_reg <= 1'b1;
                irq_reg   <= 1'b0;
            end
        end
    end

    assign instr = instr_reg;
    assign pc4   = pc4_reg;
    assign valid = valid_reg;
    assign irq   = irq_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: PC register, redirect priority and the IF/ID
// register (sub-module if_stage_ifid_reg).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   stall                         load-use hold from the hazard unit
//   id_jump, id_jump_target       jump resolved in ID
//   ex_branch, ex_branch_target   taken branch resolved in EX
//   id_exc                        undefined instruction detected in ID
//   irq                           level interrupt request
//   bus (if_stage_if.master)      imem_addr/imem_rdata and ifid_* outputs
//   irq_taken                     one-cycle pulse when an interrupt is accepted
// Optional build macro IF_PERF_CNT_EN adds perf_fetch, perf_stall and
// perf_flush 32-bit wrapping event counters.
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         id_jump,
    input  logic [31:0]  id_jump_target,
    input  logic         ex_branch,
    input  logic [31:0]  ex_branch_target,
    input  logic         id_exc,
    input  logic         irq,
    if_stage_if.master   bus,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]  perf_fetch,
    output logic [31:0]  perf_stall,
    output logic [31:0]  perf_flush,
`endif
    output logic         irq_taken
);

    redir_e      redir_sel;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic        irq_pend_reg;
    logic        irq_pend_next;
    logic        irq_taken_reg;
    logic        irq_accept;

    assign pc_inc = pc_increment(pc_reg);

    // Redirect priority. The branch beats everything because the ID-stage
    // instruction (and any jump/exception it raised) is on the wrong path.
    // Interrupts are only taken from user space and never while stalled.
    always_comb begin
        redir_sel = REDIR_NONE;
        pc_next   = pc_inc;
        if (ex_branch) begin
            redir_sel = REDIR_BR;
            pc_next   = ex_branch_target;
        end else if (id_exc) begin
            redir_sel = REDIR_EXC;
            pc_next   = EXC_VEC;
        end else if (irq_pend_reg && !pc_reg[31] && !stall) begin
            redir_sel = REDIR_IRQ;
            pc_next   = IRQ_VEC;
        end else if (stall) begin
            redir_sel = REDIR_HOLD;
            pc_next   = pc_reg;
        end else if (id_jump) begin
            redir_sel = REDIR_JMP;
            pc_next   = id_jump_target;
        end
    end

    assign irq_accept    = (redir_sel == REDIR_IRQ);
    assign irq_pend_next = irq_accept ? 1'b0 : (irq_pend_reg | irq);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= RESET_VEC;
            irq_pend_reg  <= 1'b0;
            irq_taken_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            irq_pend_reg  <= irq_pend_next;
            irq_taken_reg <= irq_accept;
        end
    end

    // The interrupt bubble carries the address of the discarded fetch so
    // that decode can save it as the return address.
    if_stage_ifid_reg u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .hold     (redir_sel == REDIR_HOLD),
        .bubble   (redir_sel inside {REDIR_BR, REDIR_EXC, REDIR_IRQ, REDIR_JMP}),
        .irq_tag  (irq_accept),
        .instr_in (bus.imem_rdata),
        .pc4_in   (irq_accept ? pc_reg : pc_inc),
        .instr    (bus.ifid_instr),
        .pc4      (bus.ifid_pc4),
        .valid    (bus.ifid_valid),
        .irq      (bus.ifid_irq)
    );

    assign bus.imem_addr = pc_reg;
    assign irq_taken     = irq_taken_reg;

`ifdef IF_PERF_CNT_EN
    // Event 0: valid load, 1: hold, 2: redirect bubble.
    logic [2:0]  perf_evt;
    logic [31:0] perf_cnt_reg [3];

    assign perf_evt[0] = (redir_sel == REDIR_NONE);
    assign perf_evt[1] = (redir_sel == REDIR_HOLD);
    assign perf_evt[2] = (redir_sel inside {REDIR_BR, REDIR_EXC, REDIR_IRQ, REDIR_JMP});

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (reset) begin
                    perf_cnt_reg[gi] <= 32'h0;
                end else if (perf_evt[gi]) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_fetch = perf_cnt_reg[0];
    assign perf_stall = perf_cnt_reg[1];
    assign perf_flush = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// redirect/stall/irq traffic, all checked against a cycle-level reference
// model of the fetch rules kept in this file.
module tb_if_stage;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset, stall, id_jump, ex_branch, id_exc, irq, irq_taken;
    logic [31:0] id_jump_target, ex_branch_target;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

    if_stage_if bus ();

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch        (ex_branch),
        .ex_branch_target (ex_branch_target),
        .id_exc           (id_exc),
        .irq              (irq),
        .bus              (bus.master),
`ifdef IF_PERF_CNT_EN
        .perf_fetch       (perf_fetch),
        .perf_stall       (perf_stall),
        .perf_flush       (perf_flush),
`endif
        .irq_taken        (irq_taken)
    );

    always #5 clk = ~clk;

    // Asynchronous instruction ROM: a fixed scramble of the address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign bus.imem_rdata = rom_word(bus.imem_addr);

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid, m_irq, m_taken, m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%08h exp=%08h", tag, n_step, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic step(input bit rst, input bit st, input bit jmp, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt, input bit exc, input bit ir);
        bit accept;
        logic [31:0] nxt;
        reset = rst; stall = st; id_jump = jmp; id_jump_target = jt;
        ex_branch = br; ex_branch_target = bt; id_exc = exc; irq = ir;

        if (rst) begin
            m_pc = RV; m_instr = 0; m_pc4 = 0; m_valid = 0; m_irq = 0;
            m_taken = 0; m_pend = 0;
        end else begin
            accept  = m_pend && (m_pc < 32'h8000_0000) && !st && !br && !exc;
            m_taken = accept;
            m_pend  = accept ? 1'b0 : (m_pend || ir);
            if (br || exc) begin
                m_pc = br ? bt : EV;
                m_instr = 0; m_valid = 0; m_irq = 0;
            end else if (accept) begin
                m_pc4 = m_pc; m_pc = IV;
                m_instr = 0; m_valid = 0; m_irq = 1;
            end else if (st) begin
                // everything holds
            end else if (jmp) begin
                m_pc = jt;
                m_instr = 0; m_valid = 0; m_irq = 0;
            end else begin
                nxt = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7fff_ffff);
                m_instr = rom_word(m_pc); m_pc4 = nxt;
                m_valid = 1; m_irq = 0; m_pc = nxt;
            end
        end

        @(posedge clk);
        #1;
        n_step++;
        $display("[TB] step %0d rst=%0b st=%0b jmp=%0b br=%0b exc=%0b irq=%0b pc=%08h v=%0b",
                 n_step, rst, st, jmp, br, exc, ir, bus.imem_addr, bus.ifid_valid);
        check("pc",        bus.imem_addr,        m_pc);
        check("instr",     bus.ifid_instr,       m_instr);
        check("valid",     32'(bus.ifid_valid),  32'(m_valid));
        check("ifid_irq",  32'(bus.ifid_irq),    32'(m_irq));
        check("irq_taken", 32'(irq_taken),       32'(m_taken));
        if (m_valid || m_irq) check("pc4", bus.ifid_pc4, m_pc4);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; stall = 0; id_jump = 0; ex_branch = 0; id_exc = 0; irq = 0;
        id_jump_target = 0; ex_branch_target = 0;
        #2;

        // 1: reset then sequential fetch from the reset vector
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_pc4", bus.ifid_pc4, 32'h0);
        run(1);
        check("first_pc4", bus.ifid_pc4, 32'h8000_0004);
        run(1);

        // 2: two-cycle stall at 0x10, then resume at 0x14
        step(0, 0, 1, 32'h10, 0, 0, 0, 0);
        run(1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        run(2);

        // 3: branch beats jump and stall in the same cycle
        step(0, 1, 1, 32'h80, 1, 32'h40, 0, 0);
        run(1);

        // 4: irq in supervisor space waits until user space
        step(0, 0, 1, 32'h8000_0020, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        run(2);
        step(0, 0, 1, 32'h100, 0, 0, 0, 0);
        run(2);

        // 5: exception, then exception with a simultaneous branch
        step(0, 0, 1, 32'h200, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 32'h200, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h300, 1, 0);
        run(1);

        // 6: reset mid-stall with an interrupt pending clears the pending flag
        step(0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h400, 0, 0, 0, 0);
        run(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] jt, bt;
            jt = {$urandom_range(0, 1) == 1, 31'($urandom) & 31'h0000_fffc};
            bt = {$urandom_range(0, 1) == 1, 31'($urandom) & 31'h0000_fffc};
            step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, jt, $urandom_range(0, 7) == 0, bt,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
